// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared encodings and default field widths for the serial system bus.
// Revision : 1.0
// ============================================================================
package bus_pkg;

  localparam int ADDRESS_WIDTH_DEF  = 12;
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int SID_WIDTH_DEF      = 2;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_REQ        = 4'd1;
  localparam logic [3:0] ST_TX_SID     = 4'd2;
  localparam logic [3:0] ST_TX_ADDR    = 4'd3;
  localparam logic [3:0] ST_TX_DATA    = 4'd4;
  localparam logic [3:0] ST_WAIT_SLAVE = 4'd5;
  localparam logic [3:0] ST_ACK        = 4'd6;
  localparam logic [3:0] ST_RX_DATA    = 4'd7;
  localparam logic [3:0] ST_DONE       = 4'd8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : bit_shift_reg
// Brief    : LSB-first shift register: parallel load / serial out, serial in at MSB.
// Revision : 1.0
// ============================================================================
module bit_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [WIDTH-1:0] par_o,
  output logic [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shifted = ser_i;
    end else begin : g_wn
      assign w_shifted = {ser_i, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = par_i;
    end else if (shift_i) begin
      sr_d = w_shifted;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[0];
  assign par_o = sr_q;
  // Exposes the post-shift value so a captured word can be used on the same edge.
  assign nxt_o = sr_d;

endmodule
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_port
// Brief    : Serial system bus initiator: sequences one read/write request onto the bus.
// Revision : 1.0
// ============================================================================
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int SID_WIDTH      = SID_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     rd_wrt_in,
  input  logic [SID_WIDTH-1:0]     slave_id,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     done,
  output logic                     error,
  output logic                     busy,
  output logic                     bus_req,
  output logic                     rd_wrt,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy
);

  localparam int c_bit_w  = $clog2(max_int(ADDRESS_WIDTH, DATA_WIDTH)) + 1;
  localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_bit_w-1:0]  c_sid_last  = c_bit_w'(SID_WIDTH - 1);
  localparam logic [c_bit_w-1:0]  c_addr_last = c_bit_w'(ADDRESS_WIDTH - 1);
  localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_WIDTH - 1);
  localparam logic [c_bit_w-1:0]  c_rx_last   = c_bit_w'(DATA_WIDTH);
  localparam logic [c_wait_w-1:0] c_timeout   = c_wait_w'(TIMEOUT_CYCLES);

  logic [3:0]            state_q,   state_d;
  logic [c_bit_w-1:0]    bitcnt_q,  bitcnt_d;
  logic [c_wait_w-1:0]   waitcnt_q, waitcnt_d;
  logic                  rw_q,      rw_d;
  logic                  done_q,    done_d;
  logic                  error_q,   error_d;
  logic [DATA_WIDTH-1:0] dout_q,    dout_d;

  logic                     w_load;
  logic                     w_sid_shift;
  logic                     w_addr_shift;
  logic                     w_dat_shift;
  logic                     w_sid_bit;
  logic                     w_addr_bit;
  logic                     w_dat_bit;
  logic                     w_tx_en;
  logic                     w_tx_bit;
  logic                     w_released;
  logic [c_wait_w-1:0]      w_wait_inc;
  logic [DATA_WIDTH-1:0]    w_dat_nxt;
  logic [SID_WIDTH-1:0]     w_sid_par_unused;
  logic [SID_WIDTH-1:0]     w_sid_nxt_unused;
  logic [ADDRESS_WIDTH-1:0] w_addr_par_unused;
  logic [ADDRESS_WIDTH-1:0] w_addr_nxt_unused;
  logic [DATA_WIDTH-1:0]    w_dat_par_unused;

  bit_shift_reg #(.WIDTH(SID_WIDTH)) u_sid_sr (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (w_load),
    .par_i   (slave_id),
    .shift_i (w_sid_shift),
    .ser_i   (1'b0),
    .ser_o   (w_sid_bit),
    .par_o   (w_sid_par_unused),
    .nxt_o   (w_sid_nxt_unused)
  );

  bit_shift_reg #(.WIDTH(ADDRESS_WIDTH)) u_addr_sr (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (w_load),
    .par_i   (addr_in),
    .shift_i (w_addr_shift),
    .ser_i   (1'b0),
    .ser_o   (w_addr_bit),
    .par_o   (w_addr_par_unused),
    .nxt_o   (w_addr_nxt_unused)
  );

  // Data register serves both directions: write data out, read data in at the MSB.
  bit_shift_reg #(.WIDTH(DATA_WIDTH)) u_data_sr (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (w_load),
    .par_i   (data_in),
    .shift_i (w_dat_shift),
    .ser_i   (data_bus_serial),
    .ser_o   (w_dat_bit),
    .par_o   (w_dat_par_unused),
    .nxt_o   (w_dat_nxt)
  );

  assign w_released = (slave_busy != 1'b1);
  assign w_wait_inc = waitcnt_q + c_wait_w'(1);

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    waitcnt_d    = waitcnt_q;
    rw_d         = rw_q;
    dout_d       = dout_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    w_load       = 1'b0;
    w_sid_shift  = 1'b0;
    w_addr_shift = 1'b0;
    w_dat_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_load  = 1'b1;
          rw_d    = rd_wrt_in;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_TX_SID;
      end
      ST_TX_SID: begin
        w_sid_shift = 1'b1;
        bitcnt_d    = bitcnt_q + c_bit_w'(1);
        if (bitcnt_q == c_sid_last) begin
          state_d = ST_TX_ADDR;
        end
      end
      ST_TX_ADDR: begin
        w_addr_shift = 1'b1;
        bitcnt_d     = bitcnt_q + c_bit_w'(1);
        if (bitcnt_q == c_addr_last) begin
          state_d = (rw_q == WR) ? ST_TX_DATA : ST_WAIT_SLAVE;
        end
      end
      ST_TX_DATA: begin
        w_dat_shift = 1'b1;
        bitcnt_d    = bitcnt_q + c_bit_w'(1);
        if (bitcnt_q == c_data_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_WAIT_SLAVE: begin
        waitcnt_d = w_wait_inc;
        if (w_released) begin
          state_d = ST_ACK;
        end else if (w_wait_inc == c_timeout) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_RX_DATA;
      end
      ST_RX_DATA: begin
        // Count 0 is the bus turnaround; bits arrive on counts 1..DATA_WIDTH.
        w_dat_shift = (bitcnt_q != '0);
        bitcnt_d    = bitcnt_q + c_bit_w'(1);
        if (bitcnt_q == c_rx_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          dout_d  = w_dat_nxt;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      bitcnt_d  = '0;
      waitcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      waitcnt_q <= '0;
      rw_q      <= RD;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      waitcnt_q <= waitcnt_d;
      rw_q      <= rw_d;
      done_q    <= done_d;
      error_q   <= error_d;
      dout_q    <= dout_d;
    end
  end

  // Bus drivers decode straight from state so an async reset releases them at once.
  assign w_tx_en  = (state_q == ST_TX_SID) || (state_q == ST_TX_ADDR) ||
                    (state_q == ST_TX_DATA);
  assign w_tx_bit = (state_q == ST_TX_SID)  ? w_sid_bit  :
                    (state_q == ST_TX_ADDR) ? w_addr_bit : w_dat_bit;

  assign data_bus_serial = w_tx_en ? w_tx_bit : 1'bz;
  assign slave_busy      = (state_q == ST_ACK) ? 1'b1 : 1'bz;

  assign bus_req  = (state_q == ST_REQ);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign data_out = dout_q;
  assign rd_wrt   = rw_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_master_port
// Brief    : Randomized self-checking bench for bus_master_port with a timeline model.
// Revision : 1.0
// ============================================================================
module tb_bus_master_port;

  localparam int SW = 2;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          rd_wrt_in = 1'b0;
  logic [SW-1:0] slave_id = '0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          done, error, busy, bus_req, rd_wrt;
  wire           data_bus_serial;
  wire           slave_busy;

  logic sd_en = 1'b0, sd_val = 1'b0, sb_en = 1'b0, sb_val = 1'b0;
  assign data_bus_serial = sd_en ? sd_val : 1'bz;
  assign slave_busy      = sb_en ? sb_val : 1'bz;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .SID_WIDTH      (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .rd_wrt_in       (rd_wrt_in),
    .slave_id        (slave_id),
    .addr_in         (addr_in),
    .data_in         (data_in),
    .data_out        (data_out),
    .done            (done),
    .error           (error),
    .busy            (busy),
    .bus_req         (bus_req),
    .rd_wrt          (rd_wrt),
    .data_bus_serial (data_bus_serial),
    .slave_busy      (slave_busy)
  );

  // One entry per clock cycle: expected DUT outputs plus what the slave side drives.
  typedef struct {
    bit          bus_req, busy, done, err, rw;
    logic [DW-1:0] dout;
    bit          sd_en, sd_val, sb_en, sb_val;
    bit          ser_exp, sb_exp;
  } exp_t;

  exp_t          expq[$];
  exp_t          plan[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl_dout = '0;
  bit            mdl_rw = 1'b0;

  task automatic chk_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Timeline of one transaction, offsets counted from the cycle start is sampled.
  function automatic void build_plan(input bit rw, input logic [SW-1:0] sid,
                                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input int dly, input logic [DW-1:0] rdata,
                                     output int len);
    int   w;
    int   ack;
    int   hold;
    bit   to;
    exp_t e;
    w   = 2 + SW + AW;
    ack = -1;
    to  = 1'b0;
    if (rw) begin
      len = w + DW;
    end else if (dly < TO) begin
      ack = w + dly + 1;
      len = ack + 2 + DW;
    end else begin
      to  = 1'b1;
      len = w + TO;
    end
    hold = to ? TO : dly;
    plan.delete();
    for (int k = 0; k <= len; k++) begin
      e         = '{default: 0};
      e.busy    = (k >= 1);
      e.bus_req = (k == 1);
      e.done    = (k == len);
      e.err     = (k == len) && to && !rw;
      e.rw      = (k >= 1) ? rw : mdl_rw;
      e.dout    = (k == len && !rw && !to) ? rdata : mdl_dout;
      if (k >= 2 && k < 2 + SW)            e.ser_exp = sid[k-2];
      else if (k >= 2 + SW && k < w)       e.ser_exp = a[k-2-SW];
      else if (rw && k >= w && k < w + DW) e.ser_exp = d[k-w];
      if (!rw) begin
        if (k >= w && k < w + hold) begin
          e.sb_en  = 1'b1;
          e.sb_val = 1'b1;
        end else if (!to && k == w + dly) begin
          e.sb_en  = 1'b1;
          e.sb_val = 1'b0;
        end
        e.sb_exp = (k == ack);
        if (!to && k >= ack + 2 && k < ack + 2 + DW) begin
          e.sd_en  = 1'b1;
          e.sd_val = rdata[k-ack-2];
        end
      end
      plan.push_back(e);
    end
    mdl_rw = rw;
    if (!rw && !to) mdl_dout = rdata;
  endfunction

  // smode: 0 = start low during the transaction, 1 = start toggles, 2 = start held high.
  task automatic run_txn(input bit rw, input logic [SW-1:0] sid, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int dly, input logic [DW-1:0] rdata,
                         input int smode, output int obs_done, output bit obs_err,
                         output logic [31:0] cap);
    int len;
    build_plan(rw, sid, a, d, dly, rdata, len);
    obs_done = -1;
    obs_err  = 1'b0;
    cap      = '0;
    for (int k = 0; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k > 0 && done === 1'b1 && obs_done < 0) begin
        obs_done = k;
        obs_err  = (error === 1'b1);
      end
      if (k >= 2 && k < 34) cap[k-2] = (data_bus_serial === 1'b1);
      if (k == 0) begin
        start     = 1'b1;
        rd_wrt_in = rw;
        slave_id  = sid;
        addr_in   = a;
        data_in   = d;
        foreach (plan[i]) expq.push_back(plan[i]);
      end else begin
        if (smode == 2)      start = 1'b1;
        else if (smode == 1) start = 1'($urandom);
        else                 start = 1'b0;
        if (smode != 0) begin
          rd_wrt_in = 1'($urandom);
          slave_id  = SW'($urandom);
          addr_in   = AW'($urandom);
          data_in   = DW'($urandom);
        end
      end
      sd_en  = plan[k].sd_en;
      sd_val = plan[k].sd_val;
      sb_en  = plan[k].sb_en;
      sb_val = plan[k].sb_val;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      start  = 1'b0;
      sd_en  = 1'b0;
      sb_en  = 1'b0;
      e      = '{default: 0};
      e.rw   = mdl_rw;
      e.dout = mdl_dout;
      expq.push_back(e);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk_b({tag, "_busy"},    busy, 1'b0);
    chk_b({tag, "_bus_req"}, bus_req, 1'b0);
    chk_b({tag, "_done"},    done, 1'b0);
    chk_b({tag, "_error"},   error, 1'b0);
    chk_b({tag, "_rd_wrt"},  rd_wrt, 1'b0);
    chk_d({tag, "_data_out"}, data_out, '0);
    chk_b({tag, "_serial_released"}, data_bus_serial === 1'b1, 1'b0);
    chk_b({tag, "_sbusy_released"},  slave_busy === 1'b1, 1'b0);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk_b("bus_req",  bus_req, e.bus_req);
        chk_b("busy",     busy, e.busy);
        chk_b("done",     done, e.done);
        chk_b("error",    error, e.err);
        chk_b("rd_wrt",   rd_wrt, e.rw);
        chk_d("data_out", data_out, e.dout);
        if (!e.sd_en) chk_b("serial", data_bus_serial === 1'b1, e.ser_exp);
        if (!e.sb_en) chk_b("slave_busy", slave_busy === 1'b1, e.sb_exp);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          od;
    bit          oe;
    logic [31:0] cap;
    logic [AW-1:0] ra;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Directed write: sid 2'b10, addr A5C, data 3C
    run_txn(1'b1, 2'b10, 12'hA5C, 8'h3C, 0, 8'h00, 0, od, oe, cap);
    chk_i("wr_done_offset", od, 24);
    chk_i("wr_stream", int'(cap[21:0]), int'({8'h3C, 12'hA5C, 2'b10}));
    idle(1);

    // Directed read: release 5 cycles after address, slave returns 96
    run_txn(1'b0, 2'b01, 12'h123, 8'h00, 5, 8'h96, 0, od, oe, cap);
    chk_i("rd_done_offset", od, 32);
    chk_b("rd_error", oe, 1'b0);
    idle(1);
    chk_d("rd_data_out", data_out, 8'h96);

    // Release already seen on first wait cycle
    run_txn(1'b0, 2'b11, 12'h0F0, 8'h00, 0, 8'h5A, 0, od, oe, cap);
    chk_i("rd_fast_done_offset", od, 27);
    idle(2);

    // Timeout: slave never releases
    run_txn(1'b0, 2'b00, 12'h800, 8'h00, TO, 8'hFF, 0, od, oe, cap);
    chk_i("to_done_offset", od, 16 + TO);
    chk_b("to_error", oe, 1'b1);
    idle(1);
    chk_d("to_data_kept", data_out, 8'h5A);

    // Back-to-back with start held high, then a toggling start
    run_txn(1'b1, 2'b01, 12'h3A7, 8'hE1, 0, 8'h00, 2, od, oe, cap);
    run_txn(1'b0, 2'b10, 12'h055, 8'h00, 3, 8'hC3, 1, od, oe, cap);
    chk_i("b2b_rd_done_offset", od, 16 + 3 + 11);
    idle(2);

    // Asynchronous reset in the middle of the address phase
    @(posedge clk);
    #1;
    start     = 1'b1;
    rd_wrt_in = 1'b1;
    slave_id  = 2'b11;
    addr_in   = 12'hFFF;
    data_in   = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk_b("pre_rst_serial", data_bus_serial === 1'b1, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rstn     = 1'b1;
    mdl_dout = '0;
    mdl_rw   = 1'b0;
    idle(1);
    run_txn(1'b1, 2'b01, 12'h6B2, 8'h7E, 0, 8'h00, 0, od, oe, cap);
    chk_i("post_rst_wr_done_offset", od, 24);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      ra = AW'($urandom);
      run_txn(1'($urandom), SW'($urandom), ra, DW'($urandom),
              int'($urandom_range(0, 20)), DW'($urandom),
              int'($urandom_range(0, 2)), od, oe, cap);
      if (od < 0) chk_i("rand_done_seen", od, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
